mcycle_unit: RTL
================

# mcycle_unit

Iterative multi-cycle arithmetic unit and sequencer for the processor's MUL, MLA, UMULL and DIV instructions. It accepts a one-cycle start request from the execute stage, holds Busy so the pipeline stalls, runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, and pulses Done with both result words. Decode drives the MCycleOp/MCAdd/MCLong selects.

## Interface
- WIDTH, 32, operand and result width in bits.
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE or DONE.
- MCycleOp  input  1  0 = multiply, 1 = divide.
- MCAdd  input  1  1 = add Operand3 to low product (MLA); ignored for divide.
- MCLong  input  1  1 = high result word is written back (UMULL).
- Operand1  input  WIDTH  multiplicand or dividend, unsigned.
- Operand2  input  WIDTH  multiplier or divisor, unsigned.
- Operand3  input  WIDTH  MLA accumulator.
- Result1  output  WIDTH  low product, MLA sum or quotient.
- Result2  output  WIDTH  high product or remainder.
- WriteHi  output  1  latched MCLong, valid with Done.
- Busy  output  1  high in COMPUTE and ACCUM.
- Done  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, COMPUTE, ACCUM, DONE. Reset: IDLE, count 0; Result1, Result2, WriteHi, Busy, Done all 0.
- IDLE/DONE + Start: latch operands, MCycleOp, MCAdd, MCLong; go to COMPUTE; clear count and the 2·WIDTH working register.
- IDLE/DONE without Start: DONE goes to IDLE; IDLE stays.
- COMPUTE, multiply: each cycle, if multiplier LSB = 1, add multiplicand to the upper half. Shift right one place. Product is exact at 2·WIDTH bits.
- COMPUTE, divide: each cycle, shift remainder:dividend left one place. If remainder ≥ divisor, subtract and set quotient bit to 1.
- After the WIDTH-th iteration: go to ACCUM if multiply with MCAdd = 1, otherwise DONE.
- ACCUM: Result1 = low product + Operand3 mod 2^WIDTH. Carry is discarded and Result2 is unchanged. Then go to DONE.
- DONE: Done = 1 and Result1/Result2/WriteHi are valid. Results hold until the next Start is accepted.
- Divide by zero is detected at Start. The unit skips COMPUTE and goes straight to DONE with Result1 = all ones and Result2 = Operand1.
- Start while Busy is ignored; the operation in flight is not disturbed.
- RESET mid-operation aborts to IDLE with all outputs cleared; no Done is produced.

## Timing
- Let E0 be the edge where Start is accepted.
- Busy is high from after E0 through E_WIDTH (WIDTH cycles), or through E_WIDTH+1 for MLA.
- Done is high for exactly one cycle after E_WIDTH (mul/div) or E_WIDTH+1 (MLA). Divide by zero: one cycle after E0.
- Busy and Done are never high together.
- Busy is registered. The pipeline stalls on (Start | Busy) and releases when Done is seen.
- Back-to-back: Start asserted during the Done cycle is accepted on that edge, so there is no idle gap.

## Configuration
- MCYCLE_DIV_EN defined: divide datapath and divide-by-zero handling are compiled in.
- MCYCLE_DIV_EN undefined: no divide logic. Start with MCycleOp = 1 goes directly to DONE, with Done one cycle after E0 and Result1 = Result2 = 0. Multiply is unaffected.

## Test plan
- MUL 0x0000_0007 × 0x0000_0006 -> Busy 32 cycles, Done in cycle 33, Result1 = 0x2A, Result2 = 0, WriteHi = 0.
- UMULL 0xFFFF_FFFF × 0xFFFF_FFFF, MCLong = 1 -> Result2 = 0xFFFF_FFFE, Result1 = 0x0000_0001, WriteHi = 1.
- MLA 0x10 × 0x10 + 0xFFFF_FFFF -> Busy 33 cycles, Result1 = 0x0000_00FF, Result2 = 0.
- DIV 100 / 7 -> Done in cycle 33, Result1 = 14, Result2 = 2. DIV 5 / 0 -> Done in cycle 1, Result1 = 0xFFFF_FFFF, Result2 = 5.
- Start pulsed while Busy -> ignored, first result unchanged. New Start during Done -> second operation begins next cycle.
- RESET asserted at cycle 10 of a multiply -> Busy, Done, Result1, Result2 = 0 immediately; state returns to IDLE and no Done pulse follows.

Source files
------------

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative shift-add multiply / restoring divide sequencer for MUL, MLA, UMULL, DIV.
// Define MCYCLE_DIV_EN to compile in the divide datapath and divide-by-zero handling.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic             MCAdd,
  input  logic             MCLong,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [WIDTH-1:0] Operand3,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             WriteHi,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, COMPUTE, ACCUM, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] count;
  logic [2*WIDTH-1:0] work, work_nx;
  logic [WIDTH-1:0] opnd, acc, skip_r1, skip_r2;
  logic [WIDTH:0] sum;
  logic add, accept, last, skip;
`ifdef MCYCLE_DIV_EN
  logic is_div, ge;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH-1:0] diff;
  assign skip = MCycleOp && Operand2 == '0;
  assign skip_r1 = '1;
  assign skip_r2 = Operand1;
`else
  assign skip = MCycleOp;
  assign skip_r1 = '0;
  assign skip_r2 = '0;
`endif
  assign accept = Start && (state == IDLE || state == DONE);
  assign last = count == CW'(WIDTH - 1);
  // Multiply keeps the multiplier in the low half; divide keeps remainder:dividend.
  always_comb begin
    sum = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    work_nx = {sum, work[WIDTH-1:1]};
`ifdef MCYCLE_DIV_EN
    rem_sh = work[2*WIDTH-1:WIDTH-1];
    ge = rem_sh >= {1'b0, opnd};
    diff = rem_sh[WIDTH-1:0] - opnd;
    if (is_div) work_nx = {ge ? diff : rem_sh[WIDTH-1:0], work[WIDTH-2:0], ge};
`endif
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = accept ? (skip ? DONE : COMPUTE) : IDLE;
      COMPUTE:    nxt = last ? (add ? ACCUM : DONE) : COMPUTE;
      ACCUM:      nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      count <= '0;
      work <= '0;
      opnd <= '0;
      acc <= '0;
      add <= 1'b0;
`ifdef MCYCLE_DIV_EN
      is_div <= 1'b0;
`endif
      Result1 <= '0;
      Result2 <= '0;
      WriteHi <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      state <= nxt;
      Busy <= nxt == COMPUTE || nxt == ACCUM;
      Done <= nxt == DONE;
      if (accept) begin
        count <= '0;
        work <= {{WIDTH{1'b0}}, MCycleOp ? Operand1 : Operand2};
        opnd <= MCycleOp ? Operand2 : Operand1;
        acc <= Operand3;
        add <= MCAdd && !MCycleOp;
`ifdef MCYCLE_DIV_EN
        is_div <= MCycleOp;
`endif
        WriteHi <= MCLong;
        if (skip) begin
          Result1 <= skip_r1;
          Result2 <= skip_r2;
        end
      end else if (state == COMPUTE) begin
        count <= count + 1'b1;
        work <= work_nx;
        if (last) {Result2, Result1} <= work_nx;
      end else if (state == ACCUM) begin
        Result1 <= Result1 + acc;
      end
    end
  end
endmodule
